// File: rtl/wb_pkg.sv
// Shared Wishbone burst definitions: cycle-type and burst-type encodings plus
// the next-address rule used by burst targets.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    localparam int BURST_ADDR_W = 32;

    // Word address of the beat following addr. Callers truncate the result to
    // their RAM depth, which gives the modulo-depth wrap for linear bursts.
    function automatic logic [BURST_ADDR_W-1:0] next_burst_addr(
        input logic [BURST_ADDR_W-1:0] addr,
        input cti_e                    cti,
        input bte_e                    bte
    );
        logic [BURST_ADDR_W-1:0] w_inc;
        w_inc           = addr + 32'd1;
        next_burst_addr = addr;
        if (cti == INCR) begin
            case (bte)
                LINEAR: next_burst_addr = w_inc;
                WRAP4:  next_burst_addr = {addr[BURST_ADDR_W-1:2], w_inc[1:0]};
                WRAP8:  next_burst_addr = {addr[BURST_ADDR_W-1:3], w_inc[2:0]};
                WRAP16: next_burst_addr = {addr[BURST_ADDR_W-1:4], w_inc[3:0]};
                default: next_burst_addr = w_inc;
            endcase
        end
    endfunction

endpackage

// File: rtl/wb_burst_ram_target_if.sv
// Wishbone B4 bus bundle between one master and the RAM target.
interface wb_burst_ram_target_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat_w;
    logic [DATA_W/8-1:0] sel;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [2:0]          cti;
    logic [1:0]          bte;
    logic [DATA_W-1:0]   dat_r;
    logic                ack;
    logic                err;

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we, cti, bte,
        output dat_r, ack, err
    );

    modport master (
        output adr, dat_w, sel, cyc, stb, we, cti, bte,
        input  dat_r, ack, err
    );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Burst word-address register: loaded at the start of a cycle, advanced on
// each completed beat. o_next is the address the next beat will use, so the
// RAM can be read ahead of the ACK.
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_addr,
    input  logic          i_adv,
    input  cti_e          i_cti,
    input  bte_e          i_bte,
    output logic [AW-1:0] o_cur,
    output logic [AW-1:0] o_next
);

    logic [AW-1:0] r_cur;

    assign o_cur  = r_cur;
    assign o_next = AW'(next_burst_addr(BURST_ADDR_W'(r_cur), i_cti, i_bte));

    // Current address: load wins over advance; held otherwise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cur <= '0;
        end else if (i_load) begin
            r_cur <= i_load_addr;
        end else if (i_adv) begin
            r_cur <= o_next;
        end
    end

endmodule

// File: rtl/wb_burst_ram_target.sv
// Wishbone B4 registered-feedback RAM slave with classic, constant and
// incrementing (linear / wrap-4/8/16) bursts. Out-of-window accesses are
// answered with a single ERR and never touch the RAM.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no cycle in progress; sample CYC&STB and latch the request
// ST_WAIT  | inserting wait states before the first ACK/ERR
// ST_BEAT  | first ACK/ERR of the cycle is on the bus
// ST_BURST | back-to-back ACKs while CYC&STB, address advanced per beat
module wb_burst_ram_target
    import wb_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
    parameter int                       WAIT_STATES   = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    wb_burst_ram_target_if.slave   wb
);

    localparam int SEL_W    = WB_DATA_WIDTH / 8;
    localparam int A        = $clog2(SEL_W);
    localparam int DEPTH    = 2 ** MEM_ADDR_BITS;
    localparam int WIN_BITS = MEM_ADDR_BITS + A;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT, ST_BURST} state_e;

    state_e                     r_state;
    state_e                     w_nstate;
    logic [3:0]                 r_cnt;
    logic [3:0]                 w_cnt_nxt;
    logic                       r_we;
    cti_e                       r_cti;
    bte_e                       r_bte;
    logic                       r_win;
    logic                       r_ack;
    logic                       r_err;
    logic [WB_DATA_WIDTH-1:0]   r_dat_r;
    logic [WB_DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                       w_ack_nxt;
    logic                       w_err_nxt;
    logic                       w_load;
    logic                       w_adv;
    logic [MEM_ADDR_BITS-1:0]   w_rd_idx;
    logic [MEM_ADDR_BITS-1:0]   w_cur;
    logic [MEM_ADDR_BITS-1:0]   w_next;
    logic [MEM_ADDR_BITS-1:0]   w_bus_idx;
    logic [WB_ADDR_WIDTH-1:0]   w_offset;
    logic                       w_in_win;
    logic                       w_cyc_stb;
    logic                       w_beat_done;
    logic                       w_cti_go;
    logic                       w_we_eff;
    logic                       w_wr_en;
    cti_e                       w_bus_cti;

    assign w_bus_idx   = wb.adr[WIN_BITS-1:A];
    assign w_offset    = wb.adr - ADDR_BASE;
    assign w_in_win    = (wb.adr >= ADDR_BASE) && ((w_offset >> WIN_BITS) == '0);
    assign w_cyc_stb   = wb.cyc & wb.stb;
    assign w_beat_done = wb.cyc & wb.stb & r_ack;
    assign w_bus_cti   = cti_e'(wb.cti);
    assign w_cti_go    = (w_bus_cti == CONST) || (w_bus_cti == INCR);
    assign w_we_eff    = w_load ? wb.we : r_we;
    // r_ack is only ever set for in-window beats, so no extra window gating.
    assign w_wr_en     = rstn & w_beat_done & r_we;

    assign wb.ack   = r_ack;
    assign wb.err   = r_err;
    assign wb.dat_r = r_dat_r;

    wb_burst_addr_gen #(
        .AW (MEM_ADDR_BITS)
    ) u_addr_gen (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_load),
        .i_load_addr (w_bus_idx),
        .i_adv       (w_adv),
        .i_cti       (w_bus_cti),
        .i_bte       (r_bte),
        .o_cur       (w_cur),
        .o_next      (w_next)
    );

    // Next state, next ACK/ERR and the RAM address to read for the next cycle.
    always_comb begin
        w_nstate  = r_state;
        w_cnt_nxt = r_cnt;
        w_ack_nxt = 1'b0;
        w_err_nxt = 1'b0;
        w_load    = 1'b0;
        w_adv     = 1'b0;
        w_rd_idx  = w_cur;
        case (r_state)
            ST_IDLE: begin
                if (w_cyc_stb) begin
                    w_load    = 1'b1;
                    w_rd_idx  = w_bus_idx;
                    w_cnt_nxt = WS_LOAD;
                    if (WAIT_STATES > 0) begin
                        w_nstate = ST_WAIT;
                    end else begin
                        w_nstate  = ST_BEAT;
                        w_ack_nxt = w_in_win;
                        w_err_nxt = !w_in_win;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb.cyc) begin
                    w_nstate = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_nstate  = ST_BEAT;
                    w_ack_nxt = r_win;
                    w_err_nxt = !r_win;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_BEAT: begin
                // Error responses and classic requests always end here.
                if (!wb.cyc || !r_win || !((r_cti == CONST) || (r_cti == INCR))) begin
                    w_nstate = ST_IDLE;
                end else begin
                    w_nstate = ST_BURST;
                    if (w_beat_done) begin
                        if (w_cti_go) begin
                            w_adv     = 1'b1;
                            w_rd_idx  = w_next;
                            w_ack_nxt = 1'b1;
                        end else begin
                            w_nstate = ST_IDLE;
                        end
                    end
                end
            end
            ST_BURST: begin
                if (!wb.cyc) begin
                    w_nstate = ST_IDLE;
                end else if (w_beat_done) begin
                    if (w_cti_go) begin
                        w_adv     = 1'b1;
                        w_rd_idx  = w_next;
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else if (wb.stb) begin
                    // Resuming after a pause: re-present the held address.
                    w_ack_nxt = 1'b1;
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    // FSM state, latched request attributes and registered bus responses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_cti   <= CLASSIC;
            r_bte   <= LINEAR;
            r_win   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_r <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_we  <= wb.we;
                r_cti <= w_bus_cti;
                r_bte <= bte_e'(wb.bte);
                r_win <= w_in_win;
            end
            r_dat_r <= (w_ack_nxt && !w_we_eff) ? r_mem[w_rd_idx] : '0;
        end
    end

    // Byte-lane RAM write on each completed write beat; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb.sel[b]) begin
                    r_mem[w_cur][b*8 +: 8] <= wb.dat_w[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_ram_target.sv
// Self-checking bench: one zero-wait-state target and one two-wait-state
// target share a single bus master; responses are checked against a queue of
// expected beats filled as each beat is driven.
module tb_wb_burst_ram_target;

    localparam logic [2:0] C_CLS = 3'b000;
    localparam logic [2:0] C_INC = 3'b010;
    localparam logic [2:0] C_EOB = 3'b111;

    typedef struct packed {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dsel;
    logic [31:0] m_adr;
    logic [31:0] m_dat_w;
    logic [3:0]  m_sel;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        s_ack;
    logic        s_err;
    logic [31:0] s_dat_r;

    logic [31:0] b_adr [16];
    logic [31:0] b_dat [16];
    logic [31:0] b_exp [16];
    logic [3:0]  b_sel [16];
    logic [2:0]  b_cti [16];

    exp_t        sb_q [$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_bad   = 0;

    wb_burst_ram_target_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    wb_burst_ram_target_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.adr   = m_adr;
    assign bus0.dat_w = m_dat_w;
    assign bus0.sel   = m_sel;
    assign bus0.cyc   = m_cyc & ~dsel;
    assign bus0.stb   = m_stb;
    assign bus0.we    = m_we;
    assign bus0.cti   = m_cti;
    assign bus0.bte   = m_bte;
    assign bus1.adr   = m_adr;
    assign bus1.dat_w = m_dat_w;
    assign bus1.sel   = m_sel;
    assign bus1.cyc   = m_cyc & dsel;
    assign bus1.stb   = m_stb;
    assign bus1.we    = m_we;
    assign bus1.cti   = m_cti;
    assign bus1.bte   = m_bte;

    assign s_ack   = dsel ? bus1.ack   : bus0.ack;
    assign s_err   = dsel ? bus1.err   : bus0.err;
    assign s_dat_r = dsel ? bus1.dat_r : bus0.dat_r;

    wb_burst_ram_target #(.WAIT_STATES(0)) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .wb   (bus0)
    );

    wb_burst_ram_target #(.WAIT_STATES(2)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .wb   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every completed beat seen on the bus consumes one expected response.
    always @(negedge clk) begin
        if (rstn && m_cyc && m_stb && (s_ack || s_err)) begin
            check_val("sb_not_empty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_val("resp_kind", {62'd0, s_err, s_ack}, {62'd0, mon_e.is_err, ~mon_e.is_err});
                check_val("dat_r", 64'(s_dat_r), 64'(mon_e.dat));
            end
        end
    end

    task automatic set_beat(input int k, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti, input logic [31:0] exp);
        b_adr[k] = adr;
        b_dat[k] = dat;
        b_sel[k] = sel;
        b_cti[k] = cti;
        b_exp[k] = exp;
    endtask

    task automatic drive_beat(input int k, input logic we_i, input logic is_err);
        exp_t t;
        m_adr   = b_adr[k];
        m_dat_w = b_dat[k];
        m_sel   = b_sel[k];
        m_cti   = b_cti[k];
        m_stb   = 1'b1;
        t.is_err = is_err;
        t.dat    = (we_i || is_err) ? 32'd0 : b_exp[k];
        sb_q.push_back(t);
    endtask

    // Runs one bus cycle of n beats; abort_after>0 ends it early by dropping
    // CYC (abort_rst=0) or pulsing reset (abort_rst=1) after that many beats.
    task automatic run_cycle(input int n, input logic we_i, input logic [1:0] bte_i,
                             input logic is_err, input int exp_wait,
                             input int abort_after, input logic abort_rst);
        int   i;
        int   waits;
        int   gaps;
        int   exp_beats;
        logic got;
        logic got_err;
        logic tmo;
        i = 0; waits = 0; gaps = 0; tmo = 1'b0;
        exp_beats = is_err ? 1 : ((abort_after > 0) ? abort_after : n);
        m_we  = we_i;
        m_bte = bte_i;
        m_cyc = 1'b1;
        drive_beat(0, we_i, is_err);
        while (1) begin
            @(negedge clk);
            got     = s_ack | s_err;
            got_err = s_err;
            if (!got) begin
                if (i == 0) waits++;
                else gaps++;
                if (waits + gaps > 40) begin
                    tmo = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (got) begin
                i++;
                if (i == n || got_err || i == abort_after) break;
                drive_beat(i, we_i, is_err);
            end
        end
        check_val("timeout", 64'(tmo), 64'd0);
        check_val("first_wait", 64'(waits), 64'(exp_wait));
        check_val("gaps", 64'(gaps), 64'd0);
        check_val("beats", 64'(i), 64'(exp_beats));
        if (abort_after > 0 && abort_rst) begin
            rstn = 1'b0;
        end else begin
            m_cyc = 1'b0;
            m_stb = 1'b0;
        end
        if (abort_after > 0) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_val("end_ack", 64'(s_ack), 64'd0);
        check_val("end_err", 64'(s_err), 64'd0);
        check_val("end_dat", 64'(s_dat_r), 64'd0);
        rstn  = 1'b1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic classic(input logic [31:0] adr, input logic we_i, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp, input int exp_wait);
        set_beat(0, adr, dat, sel, C_CLS, exp);
        run_cycle(1, we_i, 2'b00, 1'b0, exp_wait, 0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; dsel = 1'b0;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cyc = 1'b0; m_stb = 1'b0;
        m_we = 1'b0; m_cti = '0; m_bte = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_ack0", 64'(bus0.ack), 64'd0);
        check_val("rst_err0", 64'(bus0.err), 64'd0);
        check_val("rst_dat0", 64'(bus0.dat_r), 64'd0);
        check_val("rst_ack1", 64'(bus1.ack), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // classic write then read
        classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1);
        classic(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1);

        // byte-lane write
        classic(32'h40, 1'b1, 32'h11223344, 4'hF, 32'h0, 1);
        classic(32'h40, 1'b1, 32'h0000AA00, 4'b0010, 32'h0, 1);
        classic(32'h40, 1'b0, 32'h0, 4'hF, 32'h1122AA44, 1);

        // linear burst write and read-back
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h20 + 32'(4*k), 32'(k+1), 4'hF, (k == 3) ? C_EOB : C_INC, 32'h0);
        run_cycle(4, 1'b1, 2'b00, 1'b0, 1, 0, 1'b0);
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h20 + 32'(4*k), 32'h0, 4'hF, (k == 3) ? C_EOB : C_INC, 32'(k+1));
        run_cycle(4, 1'b0, 2'b00, 1'b0, 1, 0, 1'b0);

        // wrap-4 read starting mid-block
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h30 + 32'(4*k), 32'hC + 32'(k), 4'hF, (k == 3) ? C_EOB : C_INC, 32'h0);
        run_cycle(4, 1'b1, 2'b00, 1'b0, 1, 0, 1'b0);
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h30 | ((32'h8 + 32'(4*k)) & 32'hC), 32'h0, 4'hF,
                     (k == 3) ? C_EOB : C_INC, 32'hC + 32'((2 + k) % 4));
        run_cycle(4, 1'b0, 2'b01, 1'b0, 1, 0, 1'b0);

        // linear burst wraps from the top word to word 0
        set_beat(0, 32'hFFC, 32'hA5A50001, 4'hF, C_INC, 32'h0);
        set_beat(1, 32'h000, 32'hA5A50002, 4'hF, C_EOB, 32'h0);
        run_cycle(2, 1'b1, 2'b00, 1'b0, 1, 0, 1'b0);
        classic(32'h000, 1'b0, 32'h0, 4'hF, 32'hA5A50002, 1);
        classic(32'hFFC, 1'b0, 32'h0, 4'hF, 32'hA5A50001, 1);

        // out-of-window accesses: single ERR, RAM untouched
        set_beat(0, 32'h1000, 32'h0, 4'hF, C_CLS, 32'h0);
        run_cycle(1, 1'b0, 2'b00, 1'b1, 1, 0, 1'b0);
        set_beat(0, 32'h1000, 32'h0, 4'hF, C_INC, 32'h0);
        run_cycle(4, 1'b0, 2'b00, 1'b1, 1, 0, 1'b0);
        set_beat(0, 32'h1000, 32'h00000BAD, 4'hF, C_CLS, 32'h0);
        run_cycle(1, 1'b1, 2'b00, 1'b1, 1, 0, 1'b0);
        classic(32'h000, 1'b0, 32'h0, 4'hF, 32'hA5A50002, 1);

        // two wait states, aborted bursts
        dsel = 1'b1;
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h80 + 32'(4*k), 32'h5000 + 32'(k), 4'hF, (k == 3) ? C_EOB : C_INC, 32'h0);
        run_cycle(4, 1'b1, 2'b00, 1'b0, 3, 0, 1'b0);
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h80 + 32'(4*k), 32'h6000 + 32'(k), 4'hF, (k == 3) ? C_EOB : C_INC, 32'h0);
        run_cycle(4, 1'b1, 2'b00, 1'b0, 3, 2, 1'b0);
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h80 + 32'(4*k), 32'h0, 4'hF, (k == 3) ? C_EOB : C_INC,
                     (k < 2) ? 32'h6000 + 32'(k) : 32'h5000 + 32'(k));
        run_cycle(4, 1'b0, 2'b00, 1'b0, 3, 0, 1'b0);
        run_cycle(4, 1'b0, 2'b00, 1'b0, 3, 2, 1'b1);
        classic(32'h84, 1'b0, 32'h0, 4'hF, 32'h6001, 3);
        dsel = 1'b0;
        classic(32'h10, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
